// File: rtl/inv_oai_bist.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inv_oai_bist : LFSR pattern BIST for a 9-group inverter/OAI slice array.
// Build option INV_OAI_BIST_MISR_EN adds a 36-bit response MISR on sig. Rev 1.0
// ---------------------------------------------------------------------------
module inv_oai_bist #(
  parameter int unsigned NUM_PAT = 256,
  parameter logic [35:0] SEED    = 36'h0_0000_0001
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        start,
  output logic [40:0] a_out,
  output logic [40:0] b_out,
  input  logic [40:0] c_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic [35:0] sig
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_PAT - 1);

  state_t      state;
  logic [35:0] lfsr;
  logic [15:0] pat_cnt;
  logic [15:0] err_q;
  logic        busy_q;
  logic        done_q;

  logic [35:0] pat_a;
  logic [35:0] pat_b;
  logic [35:0] expect_c;
  logic [35:0] lfsr_next;
  logic        mismatch;
  logic        unused_c_hi;

  assign pat_a     = lfsr;
  assign pat_b     = {lfsr[22:0], lfsr[35:23]};
  assign lfsr_next = {lfsr[34:0], lfsr[35] ^ lfsr[24]};

  // Golden response of one slice group: three inverters plus one OAI222.
  genvar g;
  generate
    for (g = 0; g < 9; g++) begin : g_grp
      localparam int B = 4 * g;
      assign expect_c[B]   = ~pat_a[B];
      assign expect_c[B+1] = ~pat_b[B];
      assign expect_c[B+2] = ~pat_b[B+1];
      assign expect_c[B+3] = ~((pat_a[B+1] | pat_a[B+2]) &
                               (pat_b[B+1] | pat_b[B+2]) &
                               (pat_a[B+3] | pat_b[B+3]));
    end
  endgenerate

  // Bits 40:36 of the response are floating in the array.
  assign unused_c_hi = ^c_in[40:36];
  assign mismatch    = (c_in[35:0] != expect_c);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      lfsr    <= '0;
      pat_cnt <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            lfsr    <= SEED;
            pat_cnt <= '0;
            err_q   <= '0;
          end
        end
        ST_RUN: begin
          lfsr <= lfsr_next;
          if (mismatch && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
          end
          if (pat_cnt == LAST_IDX) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            pat_cnt <= pat_cnt + 16'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef INV_OAI_BIST_MISR_EN
  logic [35:0] sig_q;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else if (state == ST_RUN) begin
      sig_q <= {sig_q[34:0], sig_q[35] ^ sig_q[24]} ^ c_in[35:0];
    end else if (start) begin
      sig_q <= '0;
    end
  end

  assign sig = sig_q;
`else
  assign sig = '0;
`endif

  assign a_out   = busy_q ? {5'b0, pat_a} : '0;
  assign b_out   = busy_q ? {5'b0, pat_b} : '0;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = done_q && (err_q == 16'd0);
  assign err_cnt = err_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_oai_bist.sv
`default_nettype none
// tb_inv_oai_bist : directed checks of inv_oai_bist against a golden array model.
module tb_inv_oai_bist;

  localparam logic [35:0] SEED_TB = 36'h0_0000_0001;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic        start1, start2, start3, start4;
  logic [40:0] a1, a2, a3, a4, b1, b2, b3, b4, c1, c2, c3, c4;
  logic        busy1, busy2, busy3, busy4, done1, done2, done3, done4;
  logic        pass1, pass2, pass3, pass4;
  logic [15:0] err1, err2, err3, err4;
  logic [35:0] sig1, sig2, sig3, sig4;

  logic [4:0] hi_rnd   = '0;
  logic       mask_on  = 1'b0;
  logic       corrupt2 = 1'b0;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] rotl13(input logic [35:0] v);
    return {v[22:0], v[35:23]};
  endfunction

  function automatic logic [35:0] lfsr_step(input logic [35:0] v);
    return {v[34:0], v[35] ^ v[24]};
  endfunction

  function automatic logic [35:0] model_e(input logic [35:0] a, input logic [35:0] b);
    logic [35:0] e;
    e = '0;
    for (int g = 0; g < 9; g++) begin
      int k;
      k = 4 * g;
      e[k]   = ~a[k];
      e[k+1] = ~b[k];
      e[k+2] = ~b[k+1];
      e[k+3] = ~((a[k+1] | a[k+2]) & (b[k+1] | b[k+2]) & (a[k+3] | b[k+3]));
    end
    return e;
  endfunction

  function automatic logic [35:0] exp_sig(input int n);
    logic [35:0] s;
    s = '0;
`ifdef INV_OAI_BIST_MISR_EN
    begin
      logic [35:0] l;
      l = SEED_TB;
      for (int i = 0; i < n; i++) begin
        s = {s[34:0], s[35] ^ s[24]} ^ model_e(l, rotl13(l));
        l = lfsr_step(l);
      end
    end
`else
    if (n < 0) s = '1;
`endif
    return s;
  endfunction

  function automatic int count_e3(input int n);
    logic [35:0] l;
    logic [35:0] e;
    int          c;
    l = SEED_TB;
    c = 0;
    for (int i = 0; i < n; i++) begin
      e = model_e(l, rotl13(l));
      if (e[3]) c++;
      l = lfsr_step(l);
    end
    return c;
  endfunction

  assign c1 = {5'b0, model_e(a1[35:0], b1[35:0])};
  assign c2 = {(mask_on ? hi_rnd : 5'b0), model_e(a2[35:0], b2[35:0]) ^ {35'b0, corrupt2}};
  assign c3 = {5'b0, model_e(a3[35:0], b3[35:0]) & ~36'h8};
  assign c4 = '0;

  always @(negedge ck) hi_rnd = 5'($urandom);

  inv_oai_bist #(.NUM_PAT(1), .SEED(SEED_TB)) u_dut1 (
    .ck(ck), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .c_in(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .sig(sig1));

  inv_oai_bist #(.NUM_PAT(256), .SEED(SEED_TB)) u_dut2 (
    .ck(ck), .rst(rst), .start(start2), .a_out(a2), .b_out(b2), .c_in(c2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .sig(sig2));

  inv_oai_bist #(.NUM_PAT(16), .SEED(SEED_TB)) u_dut3 (
    .ck(ck), .rst(rst), .start(start3), .a_out(a3), .b_out(b3), .c_in(c3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .sig(sig3));

  inv_oai_bist #(.NUM_PAT(65535), .SEED(SEED_TB)) u_dut4 (
    .ck(ck), .rst(rst), .start(start4), .a_out(a4), .b_out(b4), .c_in(c4),
    .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4), .sig(sig4));

  // Pulses start2 and follows the run, tracking the pattern sequence on a2/b2.
  task automatic run2(output int busy_n, output int pat_bad);
    logic [35:0] ml;
    ml      = SEED_TB;
    busy_n  = 0;
    pat_bad = 0;
    start2  = 1'b1;
    @(negedge ck);
    start2 = 1'b0;
    while (busy2 && busy_n < 1000) begin
      if (a2 !== {5'b0, ml} || b2 !== {5'b0, rotl13(ml)}) pat_bad++;
      ml = lfsr_step(ml);
      busy_n++;
      @(negedge ck);
    end
  endtask

  initial begin
    int bn;
    int pb;
    bit seen_done;

    rst    = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    start4 = 1'b0;
    repeat (3) @(negedge ck);
    check_vec("rst_busy", busy2, 1'b0);
    check_vec("rst_done", done2, 1'b0);
    check_vec("rst_pass", pass2, 1'b0);
    check_vec("rst_a",    a2, 41'h0);
    check_vec("rst_b",    b2, 41'h0);
    check_vec("rst_err",  err2, 16'h0);
    check_vec("rst_sig",  sig2, 36'h0);
    rst = 1'b0;
    @(negedge ck);
    check_vec("idle_busy", busy1, 1'b0);

    // Seed pattern, single compare
    start1 = 1'b1;
    @(negedge ck);
    start1 = 1'b0;
    check_vec("seed_busy", busy1, 1'b1);
    check_vec("seed_a", a1, 41'h0_0000_0001);
    check_vec("seed_b", b1, 41'h0_0000_2000);
    check_vec("seed_c", c1, 41'h0_F_FFFF_BFFE);
    @(negedge ck);
    check_vec("seed_done", done1, 1'b1);
    check_vec("seed_idle", busy1, 1'b0);
    check_vec("seed_pass", pass1, 1'b1);
    check_vec("seed_err",  err1, 16'h0);
    check_vec("seed_sig",  sig1, exp_sig(1));
    check_vec("seed_a_off", a1, 41'h0);

    // Full golden run
    run2(bn, pb);
    check_vec("full_busy_cycles", bn, 256);
    check_vec("full_pattern_seq", pb, 0);
    check_vec("full_done", done2, 1'b1);
    check_vec("full_pass", pass2, 1'b1);
    check_vec("full_err",  err2, 16'h0);
    check_vec("full_sig",  sig2, exp_sig(256));
    @(negedge ck);
    check_vec("full_hold_sig", sig2, exp_sig(256));

    // Floating upper response bits must not matter
    mask_on = 1'b1;
    run2(bn, pb);
    mask_on = 1'b0;
    check_vec("mask_busy_cycles", bn, 256);
    check_vec("mask_err",  err2, 16'h0);
    check_vec("mask_pass", pass2, 1'b1);
    check_vec("mask_sig",  sig2, exp_sig(256));

    // Stuck-at-0 on C[3]; start held through the first RUN cycles is ignored
    start3 = 1'b1;
    @(negedge ck);
    bn = 0;
    while (busy3 && bn < 1000) begin
      bn++;
      if (bn == 5) start3 = 1'b0;
      @(negedge ck);
    end
    start3 = 1'b0;
    check_vec("stuck_busy_cycles", bn, 16);
    check_vec("stuck_done", done3, 1'b1);
    check_vec("stuck_err",  err3, 16'(count_e3(16)));
    check_vec("stuck_pass", pass3, 1'b0);

    // Reset in the middle of a run with errors accumulating
    corrupt2 = 1'b1;
    start2   = 1'b1;
    @(negedge ck);
    start2 = 1'b0;
    repeat (100) @(negedge ck);
    check_vec("mid_err_before", err2, 16'd100);
    check_vec("mid_busy_before", busy2, 1'b1);
    rst = 1'b1;
    #1;
    check_vec("mid_rst_busy", busy2, 1'b0);
    check_vec("mid_rst_done", done2, 1'b0);
    check_vec("mid_rst_a",    a2, 41'h0);
    check_vec("mid_rst_b",    b2, 41'h0);
    check_vec("mid_rst_err",  err2, 16'h0);
    check_vec("mid_rst_sig",  sig2, 36'h0);
    corrupt2 = 1'b0;
    @(negedge ck);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (300) begin
      @(negedge ck);
      if (done2 || busy2) seen_done = 1'b1;
    end
    check_vec("mid_stays_idle", seen_done, 1'b0);
    run2(bn, pb);
    check_vec("rerun_busy_cycles", bn, 256);
    check_vec("rerun_pattern_seq", pb, 0);
    check_vec("rerun_err",  err2, 16'h0);
    check_vec("rerun_pass", pass2, 1'b1);
    check_vec("rerun_sig",  sig2, exp_sig(256));

    // Longest run, every pattern wrong
    start4 = 1'b1;
    @(negedge ck);
    start4 = 1'b0;
    bn = 0;
    while (busy4 && bn < 70000) begin
      bn++;
      @(negedge ck);
    end
    check_vec("sat_busy_cycles", bn, 65535);
    check_vec("sat_done", done4, 1'b1);
    check_vec("sat_err",  err4, 16'hFFFF);
    check_vec("sat_pass", pass4, 1'b0);
    repeat (2) @(negedge ck);
    check_vec("sat_err_hold",  err4, 16'hFFFF);
    check_vec("sat_done_hold", done4, 1'b1);
    start4 = 1'b1;
    @(negedge ck);
    check_vec("restart_busy", busy4, 1'b1);
    check_vec("restart_done", done4, 1'b0);
    check_vec("restart_err",  err4, 16'h0);
    @(negedge ck);
    check_vec("restart_err_count", err4, 16'h1);
    start4 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
